wb_load_store_unit: RTL and testbench
=====================================

WB_LOAD_STORE_UNIT -- requirements
Module: wb_load_store_unit

Interface
REQ-001 SHALL have parameter ADDR_W, default 32: address width; DAT_I/DAT_O fixed at 32 bits.
REQ-002 SHALL have parameter BURST_LEN, default 4: instruction-fetch beats per request; power of 2, 1..16.
REQ-003 SHALL have parameter MAX_RETRY, default 3: RTY re-issues allowed per request.
REQ-004 SHALL have parameter TIMEOUT, default 255: wait cycles per beat before abort; 1..65535.
REQ-005 SHALL use one clock; reset is synchronous and active-high; ports clk (in, 1, clock) and rst (in, 1, reset), listed first.
REQ-006 SHALL have request ports: req_valid in 1; req_ready out 1; req_op in 2 (00 fetch, 01 load, 10 store, 11 illegal); req_funct3 in 3 (RV32I size/sign); req_addr in ADDR_W; req_wdata in 32.
REQ-007 SHALL have response ports: resp_valid out 1; resp_data out 32 (extended load/fetch data); resp_err out 1; resp_last out 1 (final response of the request).
REQ-008 SHALL have Wishbone B4 master ports: ACK in 1; ERR in 1; RTY in 1; DAT_I in 32; STB out 1; CYC out 1; WE out 1; ADR out ADDR_W; DAT_O out 32; SEL out 4; CTI_O out 3.

Function
REQ-009 SHALL implement FSM states IDLE, ACCESS, BACKOFF, FAULT; req_ready = 1 only in IDLE.
REQ-010 SHALL capture op, funct3, addr and wdata on req_valid && req_ready; from IDLE go to ACCESS, or to FAULT when the request is illegal.
REQ-011 SHALL treat as illegal: op 11; load funct3 3, 6 or 7; store funct3 3 or above; halfword with addr[0] = 1; word or fetch with addr[1:0] != 0.
REQ-012 SHALL, in FAULT, issue no bus cycle and drive resp_valid = resp_err = resp_last = 1 for one cycle, then return to IDLE.
REQ-013 SHALL register all bus outputs; STB and CYC rise in the cycle after acceptance and hold until ACK, ERR, RTY or timeout.
REQ-014 SHALL drive load/store beats with CTI_O = 000 and ADR = {addr[ADDR_W-1:2], 2'b00}.
REQ-015 SHALL set SEL for byte to 1 << addr[1:0], halfword to 0011 << addr[1:0], word or fetch to 1111; WE = 1 only for store.
REQ-016 SHALL drive DAT_O with the store data replicated across lanes: byte as {4{wdata[7:0]}}, halfword as {2{wdata[15:0]}}, word unchanged.
REQ-017 SHALL extract load data from the selected lane: sign-extend for funct3 0/1, zero-extend for 4/5, pass through for 2.
REQ-018 SHALL perform a fetch as BURST_LEN beats with ADR = base + 4*beat, CYC held high across the burst, CTI_O = 010 on non-final beats and 111 on the final beat; when BURST_LEN = 1, CTI_O = 000.
REQ-019 SHALL, for each acknowledged beat, assert resp_valid for exactly one cycle, in the cycle after ACK; resp_last = 1 only on the final beat; resp_err = 0.
REQ-020 SHALL wrap ADR modulo 2^ADDR_W on a burst that crosses the top of the address space; no error.
REQ-021 SHALL resolve simultaneous ACK, ERR and RTY with priority ACK > ERR > RTY.
REQ-022 SHALL, on ERR, drop CYC and STB next cycle and respond with resp_valid = resp_err = resp_last = 1, abandoning the remaining beats.
REQ-023 SHALL, on RTY, drop STB and CYC for exactly one BACKOFF cycle, then re-issue the same beat.
REQ-024 SHALL keep one retry counter per request; the RTY that would exceed MAX_RETRY SHALL instead terminate as ERR.
REQ-025 SHALL count wait cycles per beat (reset on each ACK or re-issue); when the count reaches TIMEOUT, drop CYC/STB and terminate as ERR.
REQ-026 SHALL return to IDLE in the cycle after the final response; back-to-back requests are allowed with no idle bus cycle required between responses.

Reset
REQ-027 SHALL, on rst high at a clock edge, enter IDLE and clear STB, CYC, WE, resp_valid, resp_err, resp_last, the retry counter and the timeout counter; ADR, DAT_O, SEL, CTI_O and resp_data SHALL be 0.
REQ-028 SHALL, on reset mid-burst or mid-backoff, abandon the transfer silently with no response, and SHALL drive CYC low from the next edge.

Verification
REQ-029 Load byte, funct3 0, addr 0x103, DAT_I 0x80AA_BBCC, zero-wait ACK -> SEL 1000, CTI_O 000, resp_data 0xFFFF_FF80, resp_last = 1.
REQ-030 Store halfword, addr 0x202, wdata 0x1234 -> DAT_O 0x1234_1234, SEL 1100, WE = 1; one response with resp_err = 0.
REQ-031 Fetch at 0x1000, BURST_LEN 4, ACK every cycle -> ADR 0x1000/04/08/0C, CTI_O 010/010/010/111, four responses, resp_last on the fourth.
REQ-032 Word load, addr 0x2001 -> no STB/CYC; one-cycle response with resp_err = resp_last = 1.
REQ-033 RTY on four consecutive attempts with MAX_RETRY 3 -> three BACKOFF cycles, four bus attempts, then resp_err = 1.
REQ-034 Slave silent for 255 cycles, ACK and ERR asserted together on beat 2 of another fetch, and rst asserted mid-burst -> timeout error; ACK wins the tie; reset gives no response and CYC low next edge.

Source files
------------

// File: rtl/wb_load_store_unit.sv
// Load/store and instruction-fetch unit driving a Wishbone B4 master port.
// Handles RV32I sizing/extension, incrementing fetch bursts, retry back-off and per-beat timeout.
module wb_load_store_unit #(
    parameter int ADDR_W    = 32,
    parameter int BURST_LEN = 4,
    parameter int MAX_RETRY = 3,
    parameter int TIMEOUT   = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [1:0]        req_op,
    input  logic [2:0]        req_funct3,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    output logic [31:0]       resp_data,
    output logic              resp_err,
    output logic              resp_last,
    input  logic              ACK,
    input  logic              ERR,
    input  logic              RTY,
    input  logic [31:0]       DAT_I,
    output logic              STB,
    output logic              CYC,
    output logic              WE,
    output logic [ADDR_W-1:0] ADR,
    output logic [31:0]       DAT_O,
    output logic [3:0]        SEL,
    output logic [2:0]        CTI_O
);
    localparam int BEAT_W  = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam int RETRY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

    localparam logic [1:0] OP_FETCH = 2'b00;
    localparam logic [1:0] OP_LOAD  = 2'b01;
    localparam logic [1:0] OP_STORE = 2'b10;

    typedef enum logic [1:0] {IDLE, ACCESS, BACKOFF, FAULT} state_t;

    state_t              state_reg, state_next;
    logic [1:0]          op_reg, op_next;
    logic [2:0]          funct3_reg, funct3_next;
    logic [1:0]          addr_lo_reg, addr_lo_next;
    logic [BEAT_W-1:0]   beat_reg, beat_next;
    logic [RETRY_W-1:0]  retry_reg, retry_next;
    logic [15:0]         wait_reg, wait_next;
    logic                stb_reg, stb_next;
    logic                cyc_reg, cyc_next;
    logic                we_reg, we_next;
    logic [ADDR_W-1:0]   adr_reg, adr_next;
    logic [31:0]         dat_o_reg, dat_o_next;
    logic [3:0]          sel_reg, sel_next;
    logic [2:0]          cti_reg, cti_next;
    logic                resp_valid_reg, resp_valid_next;
    logic                resp_err_reg, resp_err_next;
    logic                resp_last_reg, resp_last_next;
    logic [31:0]         resp_data_reg, resp_data_next;

    logic                last_beat;
    logic                abort;
    logic [BEAT_W-1:0]   beat_inc;
    logic [7:0]          lane_b;
    logic [15:0]         lane_h;
    logic [31:0]         load_data;
    logic [7:0]          dat_lane [4];

    function automatic logic is_illegal(input logic [1:0] op, input logic [2:0] f3,
                                        input logic [1:0] lo);
        logic bad;
        bad = 1'b0;
        case (op)
            OP_FETCH: bad = (lo != 2'b00);
            OP_LOAD:  bad = (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7);
            OP_STORE: bad = (f3 >= 3'd3);
            default:  bad = 1'b1;
        endcase
        // Size alignment: funct3[1:0] encodes byte/half/word for both loads and stores
        if (op != OP_FETCH) begin
            if (f3[1:0] == 2'b01 && lo[0]) bad = 1'b1;
            if (f3[1:0] == 2'b10 && lo != 2'b00) bad = 1'b1;
        end
        return bad;
    endfunction

    function automatic logic [3:0] sel_for(input logic [1:0] op, input logic [2:0] f3,
                                           input logic [1:0] lo);
        if (op == OP_FETCH || f3[1:0] == 2'b10) return 4'b1111;
        else if (f3[1:0] == 2'b01)              return 4'b0011 << lo;
        else                                    return 4'b0001 << lo;
    endfunction

    function automatic logic [31:0] wdata_rep(input logic [2:0] f3, input logic [31:0] wd);
        case (f3[1:0])
            2'b00:   return {4{wd[7:0]}};
            2'b01:   return {2{wd[15:0]}};
            default: return wd;
        endcase
    endfunction

    function automatic logic [2:0] cti_for(input logic fetch, input logic [BEAT_W-1:0] beat);
        if (!fetch || BURST_LEN == 1)              return 3'b000;
        else if (beat == BEAT_W'(BURST_LEN - 1))   return 3'b111;
        else                                       return 3'b010;
    endfunction

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            assign dat_lane[gi] = DAT_I[8*gi +: 8];
        end
    endgenerate

    always_comb begin
        lane_b = dat_lane[addr_lo_reg];
        lane_h = {dat_lane[{addr_lo_reg[1], 1'b1}], dat_lane[{addr_lo_reg[1], 1'b0}]};
        case (funct3_reg)
            3'd0:    load_data = {{24{lane_b[7]}}, lane_b};
            3'd1:    load_data = {{16{lane_h[15]}}, lane_h};
            3'd4:    load_data = {24'd0, lane_b};
            3'd5:    load_data = {16'd0, lane_h};
            default: load_data = DAT_I;
        endcase
    end

    assign last_beat = (op_reg != OP_FETCH) || (beat_reg == BEAT_W'(BURST_LEN - 1));
    assign beat_inc  = beat_reg + 1'b1;

    always_comb begin
        state_next      = state_reg;
        op_next         = op_reg;
        funct3_next     = funct3_reg;
        addr_lo_next    = addr_lo_reg;
        beat_next       = beat_reg;
        retry_next      = retry_reg;
        wait_next       = wait_reg;
        stb_next        = stb_reg;
        cyc_next        = cyc_reg;
        we_next         = we_reg;
        adr_next        = adr_reg;
        dat_o_next      = dat_o_reg;
        sel_next        = sel_reg;
        cti_next        = cti_reg;
        resp_valid_next = 1'b0;
        resp_err_next   = 1'b0;
        resp_last_next  = 1'b0;
        resp_data_next  = resp_data_reg;
        abort           = 1'b0;

        case (state_reg)
            IDLE: begin
                if (req_valid) begin
                    op_next      = req_op;
                    funct3_next  = req_funct3;
                    addr_lo_next = req_addr[1:0];
                    beat_next    = '0;
                    retry_next   = '0;
                    wait_next    = '0;
                    if (is_illegal(req_op, req_funct3, req_addr[1:0])) begin
                        state_next      = FAULT;
                        resp_valid_next = 1'b1;
                        resp_err_next   = 1'b1;
                        resp_last_next  = 1'b1;
                        resp_data_next  = '0;
                    end else begin
                        state_next = ACCESS;
                        stb_next   = 1'b1;
                        cyc_next   = 1'b1;
                        we_next    = (req_op == OP_STORE);
                        adr_next   = {req_addr[ADDR_W-1:2], 2'b00};
                        sel_next   = sel_for(req_op, req_funct3, req_addr[1:0]);
                        dat_o_next = wdata_rep(req_funct3, req_wdata);
                        cti_next   = cti_for(req_op == OP_FETCH, '0);
                    end
                end
            end
            ACCESS: begin
                if (ACK) begin
                    resp_valid_next = 1'b1;
                    wait_next       = '0;
                    if (op_reg == OP_LOAD)       resp_data_next = load_data;
                    else if (op_reg == OP_FETCH) resp_data_next = DAT_I;
                    else                         resp_data_next = '0;
                    if (last_beat) begin
                        resp_last_next = 1'b1;
                        stb_next       = 1'b0;
                        cyc_next       = 1'b0;
                        we_next        = 1'b0;
                        state_next     = IDLE;
                    end else begin
                        // Burst continues with CYC/STB held; ADR wraps at the top naturally
                        beat_next = beat_inc;
                        adr_next  = adr_reg + ADDR_W'(4);
                        cti_next  = cti_for(1'b1, beat_inc);
                    end
                end else if (ERR) begin
                    abort = 1'b1;
                end else if (RTY) begin
                    if (retry_reg == RETRY_W'(MAX_RETRY)) begin
                        abort = 1'b1;
                    end else begin
                        retry_next = retry_reg + 1'b1;
                        stb_next   = 1'b0;
                        cyc_next   = 1'b0;
                        state_next = BACKOFF;
                    end
                end else if (wait_reg == 16'(TIMEOUT - 1)) begin
                    abort = 1'b1;
                end else begin
                    wait_next = wait_reg + 16'd1;
                end
            end
            BACKOFF: begin
                stb_next   = 1'b1;
                cyc_next   = 1'b1;
                wait_next  = '0;
                state_next = ACCESS;
            end
            FAULT: begin
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase

        if (abort) begin
            stb_next        = 1'b0;
            cyc_next        = 1'b0;
            we_next         = 1'b0;
            resp_valid_next = 1'b1;
            resp_err_next   = 1'b1;
            resp_last_next  = 1'b1;
            resp_data_next  = '0;
            state_next      = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= IDLE;
            op_reg         <= '0;
            funct3_reg     <= '0;
            addr_lo_reg    <= '0;
            beat_reg       <= '0;
            retry_reg      <= '0;
            wait_reg       <= '0;
            stb_reg        <= 1'b0;
            cyc_reg        <= 1'b0;
            we_reg         <= 1'b0;
            adr_reg        <= '0;
            dat_o_reg      <= '0;
            sel_reg        <= '0;
            cti_reg        <= '0;
            resp_valid_reg <= 1'b0;
            resp_err_reg   <= 1'b0;
            resp_last_reg  <= 1'b0;
            resp_data_reg  <= '0;
        end else begin
            state_reg      <= state_next;
            op_reg         <= op_next;
            funct3_reg     <= funct3_next;
            addr_lo_reg    <= addr_lo_next;
            beat_reg       <= beat_next;
            retry_reg      <= retry_next;
            wait_reg       <= wait_next;
            stb_reg        <= stb_next;
            cyc_reg        <= cyc_next;
            we_reg         <= we_next;
            adr_reg        <= adr_next;
            dat_o_reg      <= dat_o_next;
            sel_reg        <= sel_next;
            cti_reg        <= cti_next;
            resp_valid_reg <= resp_valid_next;
            resp_err_reg   <= resp_err_next;
            resp_last_reg  <= resp_last_next;
            resp_data_reg  <= resp_data_next;
        end
    end

    assign req_ready  = (state_reg == IDLE);
    assign resp_valid = resp_valid_reg;
    assign resp_err   = resp_err_reg;
    assign resp_last  = resp_last_reg;
    assign resp_data  = resp_data_reg;
    assign STB        = stb_reg;
    assign CYC        = cyc_reg;
    assign WE         = we_reg;
    assign ADR        = adr_reg;
    assign DAT_O      = dat_o_reg;
    assign SEL        = sel_reg;
    assign CTI_O      = cti_reg;
endmodule

// File: tb/tb_wb_load_store_unit.sv
// Directed plus randomized bench for wb_load_store_unit; the bench itself plays the Wishbone slave
// and checks every bus beat and response against an arithmetic reference model.
module tb_wb_load_store_unit;
    localparam int ADDR_W    = 32;
    localparam int BURST_LEN = 4;
    localparam int MAX_RETRY = 3;
    localparam int TIMEOUT   = 255;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [1:0]  req_op = '0;
    logic [2:0]  req_funct3 = '0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        resp_valid;
    logic [31:0] resp_data;
    logic        resp_err;
    logic        resp_last;
    logic        ACK = 1'b0;
    logic        ERR = 1'b0;
    logic        RTY = 1'b0;
    logic [31:0] DAT_I = '0;
    logic        STB;
    logic        CYC;
    logic        WE;
    logic [31:0] ADR;
    logic [31:0] DAT_O;
    logic [3:0]  SEL;
    logic [2:0]  CTI_O;

    int total = 0;
    int bad   = 0;

    wb_load_store_unit #(
        .ADDR_W(ADDR_W), .BURST_LEN(BURST_LEN), .MAX_RETRY(MAX_RETRY), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_data(resp_data), .resp_err(resp_err),
        .resp_last(resp_last),
        .ACK(ACK), .ERR(ERR), .RTY(RTY), .DAT_I(DAT_I),
        .STB(STB), .CYC(CYC), .WE(WE), .ADR(ADR), .DAT_O(DAT_O), .SEL(SEL), .CTI_O(CTI_O)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog observed=running expected=finished");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chkb(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic int m_size(input logic [1:0] op, input logic [2:0] f3);
        if (op == 2'd0) return 4;
        case (f3 % 4)
            0:       return 1;
            1:       return 2;
            default: return 4;
        endcase
    endfunction

    function automatic bit m_illegal(input logic [1:0] op, input logic [2:0] f3, input logic [31:0] a);
        if (op == 2'd3) return 1'b1;
        if (op == 2'd1 && (f3 == 3 || f3 == 6 || f3 == 7)) return 1'b1;
        if (op == 2'd2 && f3 >= 3) return 1'b1;
        return (a % m_size(op, f3)) != 0;
    endfunction

    function automatic logic [31:0] m_sel(input logic [1:0] op, input logic [2:0] f3, input int lane);
        int sz;
        sz = m_size(op, f3);
        if (sz == 4) return 32'd15;
        return 32'(((1 << sz) - 1) << lane);
    endfunction

    function automatic logic [31:0] m_dato(input logic [2:0] f3, input logic [31:0] wd);
        case (m_size(2'd2, f3))
            1:       return {24'd0, wd[7:0]} * 32'h0101_0101;
            2:       return {16'd0, wd[15:0]} * 32'h0001_0001;
            default: return wd;
        endcase
    endfunction

    function automatic logic [31:0] m_load(input logic [2:0] f3, input int lane, input logic [31:0] dat);
        longint v, span;
        int sz;
        sz   = m_size(2'd1, f3);
        span = longint'(1) << (8 * sz);
        v    = (longint'(dat) >> (8 * lane)) % span;
        if (f3 < 3'd4 && sz < 4 && v >= span / 2) v = v - span;
        return 32'(v);
    endfunction

    function automatic logic [31:0] m_adr(input logic [31:0] a, input int beat);
        longint v;
        v = longint'(a) - longint'(a % 4) + 4 * beat;
        return 32'(v % (longint'(1) << 32));
    endfunction

    function automatic logic [31:0] m_cti(input logic [1:0] op, input int beat);
        if (op != 2'd0 || BURST_LEN == 1) return 32'd0;
        if (beat == BURST_LEN - 1) return 32'd7;
        return 32'd2;
    endfunction

    // ---------------- stimulus helpers (start and end on a falling edge) ----------------
    task automatic accept(input logic [1:0] op, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] wd);
        for (int c = 0; c < 50 && req_ready !== 1'b1; c++) @(negedge clk);
        chkb("req_ready", req_ready, 1'b1);
        req_valid  = 1'b1;
        req_op     = op;
        req_funct3 = f3;
        req_addr   = a;
        req_wdata  = wd;
        @(negedge clk);
        req_valid  = 1'b0;
        $display("txn op=%0d f3=%0d addr=%h wdata=%h illegal=%0d", op, f3, a, wd, m_illegal(op, f3, a));
    endtask

    task automatic do_req(input logic [1:0] op, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] wd, input int maxwait, input logic [31:0] dat0,
                          input int tie_beat, input int err_beat);
        int nb, w, lane;
        logic [31:0] d;
        nb   = (op == 2'd0) ? BURST_LEN : 1;
        lane = int'(a % 4);
        accept(op, f3, a, wd);
        if (m_illegal(op, f3, a)) begin
            chkb("fault_valid", resp_valid, 1'b1);
            chkb("fault_err", resp_err, 1'b1);
            chkb("fault_last", resp_last, 1'b1);
            chkb("fault_cyc", CYC, 1'b0);
            chkb("fault_stb", STB, 1'b0);
            @(negedge clk);
            chkb("fault_once", resp_valid, 1'b0);
            chkb("fault_cyc2", CYC, 1'b0);
            return;
        end
        for (int b = 0; b < nb; b++) begin
            chkb("stb", STB, 1'b1);
            chkb("cyc", CYC, 1'b1);
            chk("adr", ADR, m_adr(a, b));
            chk("sel", 32'(SEL), m_sel(op, f3, lane));
            chkb("we", WE, op == 2'd2);
            chk("cti", 32'(CTI_O), m_cti(op, b));
            if (op == 2'd2) chk("dat_o", DAT_O, m_dato(f3, wd));
            w = int'($urandom_range(0, maxwait));
            for (int k = 0; k < w; k++) begin
                @(negedge clk);
                chkb("wait_stb", STB, 1'b1);
                chkb("wait_resp", resp_valid, 1'b0);
            end
            d = (b == 0 && dat0 != 0) ? dat0 : $urandom;
            DAT_I = d;
            if (b == err_beat) ERR = 1'b1;
            else begin
                ACK = 1'b1;
                if (b == tie_beat) begin
                    ERR = 1'b1;
                    RTY = 1'b1;
                end
            end
            @(negedge clk);
            ACK = 1'b0;
            ERR = 1'b0;
            RTY = 1'b0;
            chkb("resp_valid", resp_valid, 1'b1);
            if (b == err_beat) begin
                chkb("err_resp", resp_err, 1'b1);
                chkb("err_last", resp_last, 1'b1);
                chkb("err_cyc", CYC, 1'b0);
                chkb("err_stb", STB, 1'b0);
                return;
            end
            chkb("resp_err", resp_err, 1'b0);
            chkb("resp_last", resp_last, b == nb - 1);
            if (op == 2'd0) chk("fetch_data", resp_data, d);
            if (op == 2'd1) chk("load_data", resp_data, m_load(f3, lane, d));
            if (b == nb - 1) chkb("end_cyc", CYC, 1'b0);
        end
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int attempts, backoffs, cnt;
        bit got;
        logic [1:0]  op;
        logic [2:0]  f3;
        logic [31:0] a, r;

        repeat (3) @(negedge clk);
        chkb("rst_stb", STB, 1'b0);
        chkb("rst_cyc", CYC, 1'b0);
        chkb("rst_we", WE, 1'b0);
        chkb("rst_resp_valid", resp_valid, 1'b0);
        chkb("rst_resp_err", resp_err, 1'b0);
        chkb("rst_resp_last", resp_last, 1'b0);
        chk("rst_adr", ADR, 32'd0);
        chk("rst_dat_o", DAT_O, 32'd0);
        chk("rst_sel", 32'(SEL), 32'd0);
        chk("rst_cti", 32'(CTI_O), 32'd0);
        chk("rst_resp_data", resp_data, 32'd0);
        rst = 1'b0;
        chkb("rst_ready", req_ready, 1'b1);

        // signed byte load from lane 3, zero-wait
        do_req(2'd1, 3'd0, 32'h0000_0103, 32'd0, 0, 32'h80AA_BBCC, -1, -1);
        // halfword store in upper lanes
        do_req(2'd2, 3'd1, 32'h0000_0202, 32'h0000_1234, 0, 32'd0, -1, -1);
        // four-beat fetch, ACK every cycle
        do_req(2'd0, 3'd0, 32'h0000_1000, 32'd0, 0, 32'd0, -1, -1);
        // misaligned word load faults without a bus cycle
        do_req(2'd1, 3'd2, 32'h0000_2001, 32'd0, 0, 32'd0, -1, -1);

        // retry exhaustion
        accept(2'd1, 3'd2, 32'h0000_0300, 32'd0);
        attempts = 0;
        backoffs = 0;
        got = 1'b0;
        for (int c = 0; c < 30 && !got; c++) begin
            if (STB === 1'b1) begin
                attempts++;
                RTY = 1'b1;
            end else if (resp_valid === 1'b1) got = 1'b1;
            else backoffs++;
            if (!got) begin
                @(negedge clk);
                RTY = 1'b0;
            end
        end
        chk("rty_attempts", attempts, MAX_RETRY + 1);
        chk("rty_backoffs", backoffs, MAX_RETRY);
        chkb("rty_err", resp_err, 1'b1);
        chkb("rty_last", resp_last, 1'b1);

        // silent slave times out
        accept(2'd1, 3'd2, 32'h0000_0400, 32'd0);
        cnt = 0;
        got = 1'b0;
        for (int c = 0; c < TIMEOUT + 50 && !got; c++) begin
            if (resp_valid === 1'b1) got = 1'b1;
            else begin
                if (STB === 1'b1) cnt++;
                @(negedge clk);
            end
        end
        chk("timeout_cycles", cnt, TIMEOUT);
        chkb("timeout_err", resp_err, 1'b1);
        chkb("timeout_last", resp_last, 1'b1);
        chkb("timeout_cyc", CYC, 1'b0);

        // ACK wins a three-way tie on the second beat; ERR aborts a later burst
        do_req(2'd0, 3'd0, 32'h0000_2000, 32'd0, 1, 32'd0, 1, -1);
        do_req(2'd0, 3'd0, 32'h0000_4000, 32'd0, 1, 32'd0, -1, 2);
        do_req(2'd1, 3'd5, 32'h0000_5006, 32'd0, 2, 32'd0, -1, 0);
        // burst wrapping the top of the address space
        do_req(2'd0, 3'd0, 32'hFFFF_FFF8, 32'd0, 1, 32'd0, -1, -1);

        // reset mid-burst
        accept(2'd0, 3'd0, 32'h0000_3000, 32'd0);
        ACK = 1'b1;
        DAT_I = 32'h1111_2222;
        @(negedge clk);
        ACK = 1'b0;
        chkb("mid_beat0", resp_valid, 1'b1);
        chkb("mid_stb", STB, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        chkb("mid_rst_cyc", CYC, 1'b0);
        chkb("mid_rst_stb", STB, 1'b0);
        chkb("mid_rst_resp", resp_valid, 1'b0);
        rst = 1'b0;
        @(negedge clk);
        chkb("mid_rst_cyc2", CYC, 1'b0);
        chkb("mid_rst_resp2", resp_valid, 1'b0);

        // reset during back-off
        accept(2'd1, 3'd2, 32'h0000_0500, 32'd0);
        RTY = 1'b1;
        @(negedge clk);
        RTY = 1'b0;
        chkb("bo_stb", STB, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        chkb("bo_rst_cyc", CYC, 1'b0);
        chkb("bo_rst_resp", resp_valid, 1'b0);
        rst = 1'b0;
        @(negedge clk);
        chkb("bo_rst_cyc2", CYC, 1'b0);
        chkb("bo_rst_resp2", resp_valid, 1'b0);

        // randomized back-to-back requests
        for (int i = 0; i < 40; i++) begin
            op = 2'($urandom_range(0, 3));
            f3 = 3'($urandom_range(0, 7));
            r  = $urandom;
            a  = r & 32'hFFFF_FFF0;
            if ($urandom_range(0, 1) == 1) a = a | 32'($urandom_range(0, 3));
            do_req(op, f3, a, $urandom, 3, 32'd0, -1, -1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
